// File: rtl/afilter_sched.sv
// Run scheduler for the afilter_siso datapath: issues run strobes periodically or on trigger,
// captures the filter result and keeps saturating overrun/clip/timeout counters.
module afilter_sched #(
  parameter int PW = 16,
  parameter int TW = 8,
  parameter int DW = 18
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [PW-1:0]        period,
  input  logic [TW-1:0]        timeout,
  input  logic                 ext_trig,
  input  logic                 clear_cnts,
  output logic                 run_filter,
  input  logic                 filter_done,
  input  logic signed [DW-1:0] y_in,
  input  logic                 res_clip,
  output logic signed [DW-1:0] y_hold,
  output logic                 y_valid,
  output logic                 busy,
  output logic [7:0]           overrun_cnt,
  output logic [7:0]           clip_cnt,
  output logic [7:0]           timeout_cnt
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          tick;
  logic          run_nxt, busy_nxt, vld_nxt, cap;
  logic          ovr_inc, clip_inc, tmo_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) return v + 8'd1;
    return v;
  endfunction

  // Tick source: period counter when period>0, gated external trigger otherwise
  always_comb begin
    pcnt_nxt = pcnt;
    tick     = 1'b0;
    if (period == '0) begin
      pcnt_nxt = '0;
      tick     = ext_trig & enable;
    end else if (!enable) begin
      pcnt_nxt = period - PW'(1);
    end else if (pcnt == '0) begin
      tick     = 1'b1;
      pcnt_nxt = period - PW'(1);
    end else begin
      pcnt_nxt = pcnt - PW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    run_nxt   = 1'b0;
    busy_nxt  = busy;
    vld_nxt   = 1'b0;
    cap       = 1'b0;
    ovr_inc   = 1'b0;
    clip_inc  = 1'b0;
    tmo_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) begin
          run_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          tcnt_nxt  = timeout;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ticks landing during an outstanding run are dropped, never queued
        ovr_inc = tick;
        if (filter_done) begin
          cap       = 1'b1;
          vld_nxt   = 1'b1;
          clip_inc  = res_clip;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else if (timeout != '0) begin
          if (tcnt == TW'(1)) begin
            tmo_inc   = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            tcnt_nxt = tcnt - TW'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pcnt        <= '0;
      tcnt        <= '0;
      run_filter  <= 1'b0;
      busy        <= 1'b0;
      y_valid     <= 1'b0;
      y_hold      <= '0;
      overrun_cnt <= '0;
      clip_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      state      <= state_nxt;
      pcnt       <= pcnt_nxt;
      tcnt       <= tcnt_nxt;
      run_filter <= run_nxt;
      busy       <= busy_nxt;
      y_valid    <= vld_nxt;
      if (cap) y_hold <= y_in;
      if (clear_cnts) begin
        overrun_cnt <= '0;
        clip_cnt    <= '0;
        timeout_cnt <= '0;
      end else begin
        overrun_cnt <= sat_inc(overrun_cnt, ovr_inc);
        clip_cnt    <= sat_inc(clip_cnt, clip_inc);
        timeout_cnt <= sat_inc(timeout_cnt, tmo_inc);
      end
    end
  end

endmodule
